rhythm_judge_n: RTL and testbench



---
 rtl/rhythm_judge_n_if.sv | 38 +++
 rtl/rhythm_judge_n.sv | 217 +++++++++++++++++++++
 tb/tb_rhythm_judge_n.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rhythm_judge_n_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rhythm_judge_n_if
// Description : Control, key and judgement/score bundle of the rhythm judge.
//               slave = judge side, master = game-controller side.
// Revision    : 1.0 - initial release
// ============================================================================
interface rhythm_judge_n_if #(
  parameter int LANES   = 4,
  parameter int SCORE_W = 20,
  parameter int COMBO_W = 10
);
  logic               enable;
  logic               clear;
  logic               tick;
  logic               precision_en;
  logic [LANES-1:0]   key_in;
  logic [LANES-1:0]   note_arm;
  logic [SCORE_W-1:0] score;
  logic [COMBO_W-1:0] combo;
  logic [COMBO_W-1:0] max_combo;
  logic               judge_valid;
  logic [2:0]         judge_lane;
  logic [1:0]         judge_grade;
  logic [LANES-1:0]   judge_mask;

  modport slave (
    input  enable, clear, tick, precision_en, key_in, note_arm,
    output score, combo, max_combo, judge_valid, judge_lane, judge_grade, judge_mask
  );

  modport master (
    output enable, clear, tick, precision_en, key_in, note_arm,
    input  score, combo, max_combo, judge_valid, judge_lane, judge_grade, judge_mask
  );
endinterface
`default_nettype wire

// File: rtl/rhythm_judge_n.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rhythm_judge_n
// Description : Multi-lane rhythm-game judge. Each lane tracks the age of its
//               pending note, grades key presses by distance from the judge
//               line and accumulates score / combo / best combo.
// Revision    : 1.0 - initial release
// ============================================================================
module rhythm_judge_n #(
  parameter int LANES     = 4,
  parameter int WIN_W     = 8,
  parameter int GOOD_WIN  = 60,
  parameter int GREAT_WIN = 30,
  parameter int PERF_WIN  = 10,
  parameter int SCORE_W   = 20,
  parameter int COMBO_W   = 10
) (
  input  wire logic       clk_50m,
  input  wire logic       rst_n,
  rhythm_judge_n_if.slave bus
);

  localparam logic [0:0]       c_ST_IDLE   = 1'b0;
  localparam logic [0:0]       c_ST_ARMED  = 1'b1;
  localparam logic [WIN_W-1:0] c_JUDGE_AGE = WIN_W'(GOOD_WIN);
  localparam logic [WIN_W-1:0] c_LAST_AGE  = WIN_W'(2 * GOOD_WIN - 1);
  localparam logic [WIN_W-1:0] c_PERF      = WIN_W'(PERF_WIN);
  localparam logic [WIN_W-1:0] c_GREAT     = WIN_W'(GREAT_WIN);
  localparam logic [1:0]       c_GR_MISS   = 2'd0;
  localparam logic [1:0]       c_GR_GOOD   = 2'd1;
  localparam logic [1:0]       c_GR_GREAT  = 2'd2;
  localparam logic [1:0]       c_GR_PERF   = 2'd3;
  // 8 lanes * 300 points * x4 fits comfortably in 16 bits
  localparam int               c_SUM_W     = 16;
  localparam int               c_ACC_W     = ((SCORE_W > c_SUM_W) ? SCORE_W : c_SUM_W) + 1;
  localparam logic [c_ACC_W-1:0] c_SCORE_MAX = c_ACC_W'({SCORE_W{1'b1}});
  localparam logic [COMBO_W:0]   c_COMBO_MAX = (COMBO_W + 1)'({COMBO_W{1'b1}});

  logic [0:0]         state_q [LANES];
  logic [0:0]         state_d [LANES];
  logic [WIN_W-1:0]   age_q   [LANES];
  logic [WIN_W-1:0]   age_d   [LANES];
  logic [LANES-1:0]   key_q;

  logic               w_run;
  logic [LANES-1:0]   w_edge;
  logic [LANES-1:0]   w_judged;
  logic [1:0]         w_grade [LANES];
  logic [WIN_W-1:0]   w_dist  [LANES];

  logic [COMBO_W-1:0] w_tens;
  logic [2:0]         w_mult;
  logic [c_SUM_W-1:0] w_add;
  logic [3:0]         w_hits;
  logic               w_any_miss;
  logic [2:0]         w_low_lane;
  logic [1:0]         w_low_grade;
  logic [c_ACC_W-1:0] w_score_sum;
  logic [COMBO_W:0]   w_combo_sum;
  logic [SCORE_W-1:0] score_d;
  logic [COMBO_W-1:0] combo_d;
  logic [COMBO_W-1:0] max_combo_d;

  logic [SCORE_W-1:0] score_q;
  logic [COMBO_W-1:0] combo_q;
  logic [COMBO_W-1:0] max_combo_q;
  logic               valid_q;
  logic [2:0]         lane_q;
  logic [1:0]         grade_q;
  logic [LANES-1:0]   mask_q;

  // clear overrides enable; a frozen or cleared game issues nothing
  assign w_run  = bus.enable & ~bus.clear;
  assign w_edge = bus.key_in & ~key_q;

  // Key level sampler: runs every cycle regardless of enable/clear
  always_ff @(posedge clk_50m) begin
    if (!rst_n) key_q <= '0;
    else        key_q <= bus.key_in;
  end

  // Lane FSM state and age registers
  always_ff @(posedge clk_50m) begin
    for (int i = 0; i < LANES; i++) begin
      if (!rst_n) begin
        state_q[i] <= c_ST_IDLE;
        age_q[i]   <= '0;
      end else begin
        state_q[i] <= state_d[i];
        age_q[i]   <= age_d[i];
      end
    end
  end

  // Lane FSM next state: arm, judge-and-return, re-arm, age on tick
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      state_d[i] = state_q[i];
      age_d[i]   = age_q[i];
      if (bus.clear) begin
        state_d[i] = c_ST_IDLE;
        age_d[i]   = '0;
      end else if (bus.enable) begin
        if (state_q[i] == c_ST_ARMED) begin
          if (bus.note_arm[i]) begin
            age_d[i] = '0;
          end else if (w_edge[i]) begin
            state_d[i] = c_ST_IDLE;
            age_d[i]   = '0;
          end else if (bus.tick) begin
            if (age_q[i] == c_LAST_AGE) begin
              state_d[i] = c_ST_IDLE;
              age_d[i]   = '0;
            end else begin
              age_d[i] = age_q[i] + WIN_W'(1);
            end
          end
        end else if (bus.note_arm[i]) begin
          state_d[i] = c_ST_ARMED;
          age_d[i]   = '0;
        end
      end
    end
  end

  // Lane FSM outputs: which lanes judge this cycle and with what grade.
  // Priority inside ARMED: re-arm miss, then key edge, then timeout.
  always_comb begin
    w_judged = '0;
    for (int i = 0; i < LANES; i++) begin
      w_grade[i] = c_GR_MISS;
      w_dist[i]  = (age_q[i] >= c_JUDGE_AGE) ? (age_q[i] - c_JUDGE_AGE)
                                             : (c_JUDGE_AGE - age_q[i]);
      if (w_run) begin
        if (state_q[i] == c_ST_ARMED) begin
          if (bus.note_arm[i]) begin
            w_judged[i] = 1'b1;
          end else if (w_edge[i]) begin
            w_judged[i] = 1'b1;
            if (!bus.precision_en || (w_dist[i] <= c_PERF)) w_grade[i] = c_GR_PERF;
            else if (w_dist[i] <= c_GREAT)                  w_grade[i] = c_GR_GREAT;
            else                                            w_grade[i] = c_GR_GOOD;
          end else if (bus.tick && (age_q[i] == c_LAST_AGE)) begin
            w_judged[i] = 1'b1;
          end
        end else if (!bus.note_arm[i] && w_edge[i] && bus.precision_en) begin
          w_judged[i] = 1'b1;
        end
      end
    end
  end

  // Score, combo and reporting-lane arithmetic for this cycle's judgements
  always_comb begin
    w_tens      = combo_q / COMBO_W'(10);
    w_mult      = (w_tens >= COMBO_W'(3)) ? 3'd4 : (3'(w_tens) + 3'd1);
    w_add       = '0;
    w_hits      = '0;
    w_any_miss  = 1'b0;
    w_low_lane  = '0;
    w_low_grade = c_GR_MISS;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (w_judged[i]) begin
        w_low_lane  = 3'(i);
        w_low_grade = w_grade[i];
        if (w_grade[i] == c_GR_MISS) begin
          w_any_miss = 1'b1;
        end else begin
          w_hits = w_hits + 4'd1;
          // base points are simply grade * 100
          w_add  = w_add + c_SUM_W'(w_grade[i]) * c_SUM_W'(100) * c_SUM_W'(w_mult);
        end
      end
    end
    w_score_sum = c_ACC_W'(score_q) + c_ACC_W'(w_add);
    w_combo_sum = (COMBO_W + 1)'(combo_q) + (COMBO_W + 1)'(w_hits);
    score_d     = (w_score_sum > c_SCORE_MAX) ? '1 : w_score_sum[SCORE_W-1:0];
    if (w_any_miss)                      combo_d = COMBO_W'(w_hits);
    else if (w_combo_sum > c_COMBO_MAX)  combo_d = '1;
    else                                 combo_d = w_combo_sum[COMBO_W-1:0];
    max_combo_d = (combo_d > max_combo_q) ? combo_d : max_combo_q;
  end

  // Registered judgement strobe and score state; reset > clear > enable
  always_ff @(posedge clk_50m) begin
    if (!rst_n || bus.clear) begin
      score_q     <= '0;
      combo_q     <= '0;
      max_combo_q <= '0;
      valid_q     <= 1'b0;
      lane_q      <= '0;
      grade_q     <= c_GR_MISS;
      mask_q      <= '0;
    end else begin
      valid_q <= |w_judged;
      mask_q  <= w_judged;
      lane_q  <= w_low_lane;
      grade_q <= w_low_grade;
      if (|w_judged) begin
        score_q     <= score_d;
        combo_q     <= combo_d;
        max_combo_q <= max_combo_d;
      end
    end
  end

  assign bus.score       = score_q;
  assign bus.combo       = combo_q;
  assign bus.max_combo   = max_combo_q;
  assign bus.judge_valid = valid_q;
  assign bus.judge_lane  = lane_q;
  assign bus.judge_grade = grade_q;
  assign bus.judge_mask  = mask_q;

endmodule
`default_nettype wire

// File: tb/tb_rhythm_judge_n.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rhythm_judge_n
// Description : Scoreboard bench for rhythm_judge_n: directed scenarios plus
//               randomized play checked against a behavioural game model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rhythm_judge_n;
  localparam int LANES = 4, WIN_W = 8, GOOD_WIN = 60, GREAT_WIN = 30, PERF_WIN = 10;
  localparam int SCORE_W = 20, COMBO_W = 10;
  localparam int c_SMAX = (1 << SCORE_W) - 1;
  localparam int c_CMAX = (1 << COMBO_W) - 1;

  logic clk_50m = 1'b0;
  logic rst_n   = 1'b0;
  always #10 clk_50m = ~clk_50m;

  rhythm_judge_n_if #(.LANES(LANES), .SCORE_W(SCORE_W), .COMBO_W(COMBO_W)) bus ();

  rhythm_judge_n #(
    .LANES(LANES), .WIN_W(WIN_W), .GOOD_WIN(GOOD_WIN), .GREAT_WIN(GREAT_WIN),
    .PERF_WIN(PERF_WIN), .SCORE_W(SCORE_W), .COMBO_W(COMBO_W)
  ) dut (
    .clk_50m(clk_50m),
    .rst_n  (rst_n),
    .bus    (bus.slave)
  );

  typedef struct {
    logic [LANES-1:0] mask;
    int lane;
    int grade;
    int score;
    int combo;
    int maxc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // behavioural game model
  bit               m_armed [LANES];
  int               m_age   [LANES];
  logic [LANES-1:0] m_prev = '0;
  int               m_score = 0, m_combo = 0, m_max = 0;

  logic             pe_g  = 1'b1;
  logic [LANES-1:0] key_g = '0;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_step(output bit have, output exp_t e);
    logic [LANES-1:0] jm;
    int gr [LANES];
    int mult, add, hits, d;
    bit anymiss, edge_k;
    have = 1'b0;
    e    = '{mask: '0, lane: 0, grade: 0, score: 0, combo: 0, maxc: 0};
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) begin m_armed[i] = 0; m_age[i] = 0; end
      m_prev = '0; m_score = 0; m_combo = 0; m_max = 0;
      return;
    end
    if (bus.clear) begin
      for (int i = 0; i < LANES; i++) begin m_armed[i] = 0; m_age[i] = 0; end
      m_score = 0; m_combo = 0; m_max = 0; m_prev = bus.key_in;
      return;
    end
    if (!bus.enable) begin
      m_prev = bus.key_in;
      return;
    end
    jm = '0;
    for (int i = 0; i < LANES; i++) begin
      gr[i]  = 0;
      edge_k = bus.key_in[i] && !m_prev[i];
      if (m_armed[i]) begin
        if (bus.note_arm[i]) begin
          jm[i] = 1'b1; m_age[i] = 0;
        end else if (edge_k) begin
          d = m_age[i] - GOOD_WIN;
          if (d < 0) d = -d;
          jm[i] = 1'b1;
          if (!bus.precision_en || d <= PERF_WIN) gr[i] = 3;
          else if (d <= GREAT_WIN)                gr[i] = 2;
          else                                    gr[i] = 1;
          m_armed[i] = 0; m_age[i] = 0;
        end else if (bus.tick) begin
          if (m_age[i] + 1 >= 2 * GOOD_WIN) begin
            jm[i] = 1'b1; m_armed[i] = 0; m_age[i] = 0;
          end else begin
            m_age[i]++;
          end
        end
      end else if (bus.note_arm[i]) begin
        m_armed[i] = 1; m_age[i] = 0;
      end else if (edge_k && bus.precision_en) begin
        jm[i] = 1'b1;
      end
    end
    m_prev = bus.key_in;
    if (jm == '0) return;
    mult = 1 + m_combo / 10;
    if (mult > 4) mult = 4;
    add = 0; hits = 0; anymiss = 0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (jm[i]) begin
        e.lane  = i;
        e.grade = gr[i];
        add += gr[i] * 100 * mult;
        if (gr[i] == 0) anymiss = 1; else hits++;
      end
    end
    m_score = (m_score + add > c_SMAX) ? c_SMAX : m_score + add;
    if (anymiss) m_combo = hits;
    else         m_combo = (m_combo + hits > c_CMAX) ? c_CMAX : m_combo + hits;
    if (m_combo > m_max) m_max = m_combo;
    e.mask = jm; e.score = m_score; e.combo = m_combo; e.maxc = m_max;
    have = 1'b1;
  endtask

  // apply one cycle of inputs; expected judgement is queued at the capturing edge
  task automatic cycle(input logic en, input logic clr, input logic tk, input logic pe,
                       input logic [LANES-1:0] key, input logic [LANES-1:0] arm,
                       input logic rn);
    bit   have;
    exp_t e;
    rst_n            = rn;
    bus.enable       = en;
    bus.clear        = clr;
    bus.tick         = tk;
    bus.precision_en = pe;
    bus.key_in       = key;
    bus.note_arm     = arm;
    model_step(have, e);
    @(posedge clk_50m);
    if (have) exp_q.push_back(e);
    #1;
  endtask

  task automatic cyc(input logic tk, input logic [LANES-1:0] arm);
    cycle(1'b1, 1'b0, tk, pe_g, key_g, arm, 1'b1);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin cyc(1'b1, '0); cyc(1'b0, '0); end
  endtask

  task automatic press_on(input logic [LANES-1:0] m);
    key_g = key_g | m; cyc(1'b0, '0);
  endtask

  task automatic press_off(input logic [LANES-1:0] m);
    key_g = key_g & ~m; cyc(1'b0, '0);
  endtask

  task automatic hit(input int l);
    logic [LANES-1:0] m;
    m = LANES'(1) << l;
    cyc(1'b0, m);
    ticks(GOOD_WIN);
    press_on(m);
    press_off(m);
  endtask

  // monitor: every judgement strobe must match the head of the scoreboard
  always @(negedge clk_50m) begin : mon
    exp_t e;
    if (bus.judge_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_judge: got valid=1 mask=%b, required no judgement (t=%0t)",
                 bus.judge_mask, $time);
      end else begin
        e = exp_q.pop_front();
        chk("judge_mask",  int'(bus.judge_mask),  int'(e.mask));
        chk("judge_lane",  int'(bus.judge_lane),  e.lane);
        chk("judge_grade", int'(bus.judge_grade), e.grade);
        chk("score",       int'(bus.score),       e.score);
        chk("combo",       int'(bus.combo),       e.combo);
        chk("max_combo",   int'(bus.max_combo),   e.maxc);
      end
    end else if (exp_q.size() != 0) begin
      n_vec++; n_bad++;
      e = exp_q.pop_front();
      $display("FAIL missing_judge: got valid=%b, required mask=%b grade=%0d (t=%0t)",
               bus.judge_valid, e.mask, e.grade, $time);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.enable = 1'b0; bus.clear = 1'b0; bus.tick = 1'b0;
    bus.precision_en = 1'b1; bus.key_in = '0; bus.note_arm = '0;
    for (int i = 0; i < LANES; i++) begin m_armed[i] = 0; m_age[i] = 0; end
    @(posedge clk_50m); #1;

    // reset state
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 1'b0);
    chk("rst_score", int'(bus.score), 0);
    chk("rst_combo", int'(bus.combo), 0);
    chk("rst_max_combo", int'(bus.max_combo), 0);
    chk("rst_valid", int'(bus.judge_valid), 0);
    chk("rst_mask", int'(bus.judge_mask), 0);

    // perfect hit on the judge line
    pe_g = 1'b1;
    hit(0);
    chk("perfect_score", int'(bus.score), 300);
    chk("perfect_combo", int'(bus.combo), 1);

    // late good hit (d=35), then a timeout miss
    cyc(1'b0, 4'b0010); ticks(95); press_on(4'b0010); press_off(4'b0010);
    chk("good_score", int'(bus.score), 400);
    cyc(1'b0, 4'b0010); ticks(2 * GOOD_WIN); cyc(1'b0, '0);
    chk("timeout_combo", int'(bus.combo), 0);
    chk("timeout_score", int'(bus.score), 400);

    // multiplier: start from score 300, combo 0
    cycle(1'b1, 1'b1, 1'b0, pe_g, key_g, '0, 1'b1);
    chk("clear_score", int'(bus.score), 0);
    hit(0);
    press_on(4'b0001); press_off(4'b0001);
    chk("empty_press_combo", int'(bus.combo), 0);
    for (int k = 0; k < 10; k++) hit(0);
    chk("ten_hits_score", int'(bus.score), 3300);
    hit(0);
    chk("eleven_hits_score", int'(bus.score), 3900);
    chk("eleven_hits_combo", int'(bus.combo), 11);
    chk("eleven_hits_max", int'(bus.max_combo), 11);

    // lanes 0 and 2 perfect in the same cycle lane 3 times out (x2 multiplier)
    cyc(1'b0, 4'b1000); ticks(GOOD_WIN - 1);
    cyc(1'b0, 4'b0101); ticks(GOOD_WIN);
    key_g = key_g | 4'b0101; cyc(1'b1, '0);
    chk("multi_mask", int'(bus.judge_mask), 13);
    chk("multi_lane", int'(bus.judge_lane), 0);
    press_off(4'b0101);
    chk("multi_score", int'(bus.score), 5100);
    chk("multi_combo", int'(bus.combo), 2);
    chk("multi_max", int'(bus.max_combo), 11);

    // key press while idle
    press_on(4'b0010); press_off(4'b0010);
    chk("idle_press_combo", int'(bus.combo), 0);
    pe_g = 1'b0;
    press_on(4'b0100);
    chk("idle_press_lenient_valid", int'(bus.judge_valid), 0);
    press_off(4'b0100);
    pe_g = 1'b1;

    // reset with armed lanes and combo 5, key held through release
    for (int k = 0; k < 5; k++) hit(0);
    chk("pre_reset_combo", int'(bus.combo), 5);
    cyc(1'b0, 4'b0110);
    key_g = 4'b0001;
    cycle(1'b1, 1'b0, 1'b0, 1'b1, key_g, '0, 1'b0);
    chk("reset_score", int'(bus.score), 0);
    chk("reset_combo", int'(bus.combo), 0);
    chk("reset_max", int'(bus.max_combo), 0);
    chk("reset_valid", int'(bus.judge_valid), 0);
    cyc(1'b0, '0);
    chk("held_key_valid", int'(bus.judge_valid), 1);
    chk("held_key_grade", int'(bus.judge_grade), 0);
    press_off(4'b0001);

    // randomized play
    for (int c = 0; c < 3000; c++) begin
      logic [LANES-1:0] arm_r;
      arm_r = '0;
      for (int l = 0; l < LANES; l++) begin
        if ($urandom_range(0, 79) == 0) arm_r[l] = 1'b1;
        if ($urandom_range(0, 59) == 0) key_g[l] = ~key_g[l];
      end
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 299) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
            key_g, arm_r, 1'b1);
    end
    repeat (3) cyc(1'b0, '0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
